// File: rtl/iomem_sample_fifo_pkg.sv
// Shared register map for the iomem sample FIFO: register offsets,
// STATUS/CTRL bit positions and a STATUS word builder.
package iomem_sample_fifo_pkg;

    typedef enum logic [1:0] {
        REG_DATA   = 2'd0,
        REG_STATUS = 2'd1,
        REG_CTRL   = 2'd2,
        REG_THRESH = 2'd3
    } reg_addr_e;

    localparam int STATUS_EMPTY_BIT = 16;
    localparam int STATUS_FULL_BIT  = 17;
    localparam int STATUS_OVF_BIT   = 18;
    localparam int STATUS_UNF_BIT   = 19;

    localparam int CTRL_FLUSH_BIT   = 0;
    localparam int CTRL_CLR_OVF_BIT = 1;
    localparam int CTRL_CLR_UNF_BIT = 2;

    // count arrives zero-extended to 16 bits so the function stays depth-agnostic
    function automatic logic [31:0] status_word(input logic [15:0] count,
                                                input logic empty,
                                                input logic full,
                                                input logic ovf,
                                                input logic unf);
        logic [31:0] w;
        w                   = '0;
        w[15:0]             = count;
        w[STATUS_EMPTY_BIT] = empty;
        w[STATUS_FULL_BIT]  = full;
        w[STATUS_OVF_BIT]   = ovf;
        w[STATUS_UNF_BIT]   = unf;
        return w;
    endfunction

endpackage

// File: rtl/iomem_sample_fifo_if.sv
// Bus and DSP-side signals of the sample FIFO. The master side is the
// iomem decoder plus DSP pipeline; the slave side is the FIFO itself.
interface iomem_sample_fifo_if #(
    parameter int WIDTH = 16
);
    logic             we;
    logic             re;
    logic [1:0]       addr;
    logic [31:0]      wdata;
    logic [31:0]      rdata;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             irq;

    modport master (
        output we, re, addr, wdata, in_valid, in_data,
        input  rdata, irq
    );

    modport slave (
        input  we, re, addr, wdata, in_valid, in_data,
        output rdata, irq
    );
endinterface

// File: rtl/iomem_sample_fifo_sync_fifo.sv
// First-word fall-through FIFO: asynchronous-read storage array, wrapping
// pointers and an explicit occupancy count with push/pop/flush controls.
module iomem_sample_fifo_sync_fifo #(
    parameter int WIDTH      = 16,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  ck,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [WIDTH-1:0]      wr_data,
    output logic [WIDTH-1:0]      rd_data,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = 1;
    localparam logic [DEPTH_LOG2:0]   COUNT_ONE = 1;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_reg;
    logic [DEPTH_LOG2-1:0] rd_ptr_reg;
    logic [DEPTH_LOG2:0]   count_reg;
    logic                  push_ok;
    logic                  pop_ok;

    // count never exceeds DEPTH, so its top bit alone marks full
    assign full  = count_reg[DEPTH_LOG2];
    assign empty = (count_reg == '0);
    assign count = count_reg;

    assign pop_ok  = pop && !empty && !flush;
    // a same-edge pop frees the slot a full FIFO needs
    assign push_ok = push && !flush && (!full || pop_ok);

    assign rd_data = mem[rd_ptr_reg];

    always_ff @(posedge ck) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + COUNT_ONE;
                2'b01:   count_reg <= count_reg - COUNT_ONE;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/iomem_sample_fifo.sv
// Register-mapped capture FIFO behind the iomem decoder: DATA/STATUS/CTRL/
// THRESH registers, sticky overflow/underflow flags and a level interrupt.
module iomem_sample_fifo
    import iomem_sample_fifo_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                ck,
    input  logic                rst,
    iomem_sample_fifo_if.slave  bus
);
    reg_addr_e             addr_sel;
    logic                  pop_req;
    logic                  pop_ok;
    logic                  ctrl_wr;
    logic                  thresh_wr;
    logic                  flush;
    logic                  clr_ovf;
    logic                  clr_unf;
    logic                  ovf_set;
    logic                  unf_set;

    logic [WIDTH-1:0]      head;
    logic [DEPTH_LOG2:0]   count;
    logic                  full;
    logic                  empty;

    logic                  ovf_reg;
    logic                  unf_reg;
    logic                  irq_reg;
    logic [DEPTH_LOG2:0]   thresh_reg;

    logic [31:0]           data_ext;
    logic [15:0]           count_ext;
    logic [31:0]           rdata_mux;
    logic                  unused_wdata;

    assign addr_sel  = reg_addr_e'(bus.addr);
    assign pop_req   = bus.re && (addr_sel == REG_DATA);
    assign pop_ok    = pop_req && !empty;
    assign ctrl_wr   = bus.we && (addr_sel == REG_CTRL);
    assign thresh_wr = bus.we && (addr_sel == REG_THRESH);
    assign flush     = ctrl_wr && bus.wdata[CTRL_FLUSH_BIT];
    assign clr_ovf   = ctrl_wr && bus.wdata[CTRL_CLR_OVF_BIT];
    assign clr_unf   = ctrl_wr && bus.wdata[CTRL_CLR_UNF_BIT];

    // a push discarded by flush is not an overflow
    assign ovf_set   = bus.in_valid && full && !pop_ok && !flush;
    assign unf_set   = pop_req && empty;

    assign unused_wdata = ^bus.wdata[31:DEPTH_LOG2+1];

    iomem_sample_fifo_sync_fifo #(
        .WIDTH      (WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .ck      (ck),
        .rst     (rst),
        .push    (bus.in_valid),
        .pop     (pop_req),
        .flush   (flush),
        .wr_data (bus.in_data),
        .rd_data (head),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            ovf_reg    <= 1'b0;
            unf_reg    <= 1'b0;
            irq_reg    <= 1'b0;
            thresh_reg <= '0;
        end else begin
            if (clr_ovf) begin
                ovf_reg <= 1'b0;
            end else if (ovf_set) begin
                ovf_reg <= 1'b1;
            end
            if (clr_unf) begin
                unf_reg <= 1'b0;
            end else if (unf_set) begin
                unf_reg <= 1'b1;
            end
            if (thresh_wr) begin
                thresh_reg <= bus.wdata[DEPTH_LOG2:0];
            end
            irq_reg <= ((thresh_reg != '0) && (count >= thresh_reg)) || ovf_reg;
        end
    end

    always_comb begin
        data_ext                  = '0;
        data_ext[WIDTH-1:0]       = head;
        count_ext                 = '0;
        count_ext[DEPTH_LOG2:0]   = count;
    end

    always_comb begin
        rdata_mux = '0;
        if (bus.re) begin
            case (addr_sel)
                REG_DATA: begin
                    if (!empty) begin
                        rdata_mux = data_ext;
                    end
                end
                REG_STATUS: rdata_mux = status_word(count_ext, empty, full, ovf_reg, unf_reg);
                REG_CTRL:   rdata_mux = '0;
                REG_THRESH: rdata_mux[DEPTH_LOG2:0] = thresh_reg;
            endcase
        end
    end

    assign bus.rdata = rdata_mux;
    assign bus.irq   = irq_reg;

endmodule
